// File: rtl/gaussian_row_sequencer_if.sv
// gaussian_row_sequencer_if: handshake and status bundle between the row sequencer and its environment
// master: frame control, down-sampler FIFO and output-FIFO status side; slave: the sequencer
interface gaussian_row_sequencer_if;
  logic        start;
  logic        src_valid;
  logic [7:0]  src_din;
  logic        src_rd_en;
  logic [7:0]  gauss_din;
  logic        gauss_en;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [8:0]  row_idx;
  logic        busy;
  logic        frame_done;
  logic [15:0] stall_cycles;
  modport master (
    output start, src_valid, src_din, fifo_full,
    input  src_rd_en, gauss_din, gauss_en, fifo_wr_en, row_idx, busy, frame_done, stall_cycles
  );
  modport slave (
    input  start, src_valid, src_din, fifo_full,
    output src_rd_en, gauss_din, gauss_en, fifo_wr_en, row_idx, busy, frame_done, stall_cycles
  );
endinterface

// File: rtl/gaussian_row_sequencer.sv
// gaussian_row_sequencer: streams each row into the Gaussian stage, flushes it with LATENCY zero pads, gates output-FIFO writes
// ports: clk, rst (async active-high), bus (slave modport: start, src_valid/src_din/src_rd_en,
//        gauss_din/gauss_en, fifo_full/fifo_wr_en, row_idx, busy, frame_done, stall_cycles)
// optional: define GAUSS_SEQ_STALL_CNT_EN to count STREAM/PAD cycles blocked by fifo_full
module gaussian_row_sequencer #(
  parameter int ROW_WIDTH = 400,
  parameter int NUM_ROWS  = 300,
  parameter int LATENCY   = 2
) (
  input logic clk,
  input logic rst,
  gaussian_row_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STREAM, PAD, DONE} state_t;
  localparam int CW = $clog2(ROW_WIDTH);
  localparam int PW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_t state, nstate;
  logic [CW-1:0] col_cnt;
  logic [PW-1:0] pad_cnt;
  logic [8:0] row_idx;
  logic accept, adv, col_last, pad_last, row_last;
  always_comb begin
    accept = state == STREAM && bus.src_valid && !bus.fifo_full;
    adv = state == PAD && !bus.fifo_full;
    col_last = col_cnt == CW'(ROW_WIDTH - 1);
    pad_last = pad_cnt == PW'(LATENCY - 1);
    row_last = row_idx == 9'(NUM_ROWS - 1);
    nstate = state;
    case (state)
      IDLE:   nstate = bus.start ? STREAM : IDLE;
      STREAM: nstate = accept && col_last ? PAD : STREAM;
      PAD:    nstate = adv && pad_last ? (row_last ? DONE : STREAM) : PAD;
      DONE:   nstate = IDLE;
    endcase
    bus.src_rd_en = accept;
    bus.gauss_en = accept || adv;
    bus.gauss_din = state == STREAM ? bus.src_din : 8'd0;
    // the first LATENCY outputs of a row are pipeline warm-up and are dropped
    bus.fifo_wr_en = (accept && col_cnt >= CW'(LATENCY)) || adv;
    bus.busy = state != IDLE;
    bus.frame_done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      col_cnt <= '0;
      pad_cnt <= '0;
      row_idx <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && bus.start) begin
        col_cnt <= '0;
        row_idx <= '0;
      end
      if (accept) col_cnt <= col_last ? '0 : col_cnt + 1'b1;
      if (accept && col_last) pad_cnt <= '0;
      if (adv) pad_cnt <= pad_last ? '0 : pad_cnt + 1'b1;
      if (adv && pad_last && !row_last) row_idx <= row_idx + 1'b1;
    end
  end
  assign bus.row_idx = row_idx;
`ifdef GAUSS_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (state == IDLE && bus.start) stall_cnt <= '0;
    else if ((state == STREAM || state == PAD) && bus.fifo_full && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
  end
  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_gaussian_row_sequencer.sv
// tb_gaussian_row_sequencer: directed and randomized checks of gaussian_row_sequencer against a frame-position model
module tb_gaussian_row_sequencer;
  localparam int RW = 4, NR = 2, LAT = 2;
  localparam int SL = RW + LAT, TOT = NR * SL;
  logic clk = 0, rst = 1, ptr_clr = 0;
  logic [7:0] pix [0:255];
  logic [7:0] ptr = 0;
  int tests = 0, fails = 0;
  gaussian_row_sequencer_if bus();
  gaussian_row_sequencer #(.ROW_WIDTH(RW), .NUM_ROWS(NR), .LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.src_din = pix[ptr];
  always @(posedge clk) ptr <= ptr_clr ? 8'd0 : ptr + 8'(bus.src_rd_en);
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  // model: a frame is TOT linear shift slots; slot k lies in row k/SL, and slots with k%SL >= RW are pads
  int phase = 0, k = 0, held = 0, e_stall = 0;
  always @(negedge clk) begin
    logic run, strm, v, f, e_rd, e_en, e_wr;
    logic [7:0] e_din;
    int pos, e_row, es;
    v = bus.src_valid;
    f = bus.fifo_full;
    run = !rst && phase == 1;
    pos = k % SL;
    strm = run && pos < RW;
    e_rd = strm && v && !f;
    e_en = strm ? (v && !f) : (run && !f);
    e_wr = strm ? (v && !f && pos >= LAT) : (run && !f);
    e_din = strm ? bus.src_din : 8'd0;
    e_row = rst ? 0 : run ? k / SL : held;
`ifdef GAUSS_SEQ_STALL_CNT_EN
    es = rst ? 0 : e_stall;
`else
    es = 0;
`endif
    check("src_rd_en", bus.src_rd_en, e_rd);
    check("gauss_en", bus.gauss_en, e_en);
    check("fifo_wr_en", bus.fifo_wr_en, e_wr);
    check("gauss_din", bus.gauss_din, e_din);
    check("row_idx", bus.row_idx, e_row);
    check("busy", bus.busy, !rst && phase != 0);
    check("frame_done", bus.frame_done, !rst && phase == 2);
    check("stall_cycles", bus.stall_cycles, es);
    if (rst) begin
      phase = 0; k = 0; held = 0; e_stall = 0;
    end else if (phase == 2) phase = 0;
    else if (phase == 0) begin
      if (bus.start) begin phase = 1; k = 0; e_stall = 0; end
    end else begin
      if (f && e_stall < 65535) e_stall++;
      if (e_en) begin
        k++;
        if (k == TOT) begin phase = 2; held = NR - 1; end
      end
    end
  end
  task automatic cyc(input logic r, input logic v, input logic f, input logic s);
    @(posedge clk);
    #1;
    rst = r; bus.src_valid = v; bus.fifo_full = f; bus.start = s; ptr_clr = 0;
    @(negedge clk);
  endtask
  logic [7:0] lit [0:11] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd0, 8'd50, 8'd60, 8'd70, 8'd80, 8'd0, 8'd0};
  task automatic run_frame(input string n, input int gap_at, input int gap_len, input int done_exp);
    logic [7:0] got [$];
    int n_wr = 0, done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      cyc(0, !(c > gap_at && c <= gap_at + gap_len), 0, 0);
      if (bus.gauss_en) got.push_back(bus.gauss_din);
      if (bus.fifo_wr_en) n_wr++;
      if (bus.frame_done) done_at = c;
    end
    check({n, "_done_at"}, done_at, done_exp);
    check({n, "_writes"}, n_wr, 8);
    check({n, "_shifts"}, got.size(), 12);
    for (int i = 0; i < 12 && i < got.size(); i++) check({n, "_din_seq"}, got[i], lit[i]);
    cyc(0, 1, 0, 0);
    check({n, "_busy_after"}, bus.busy, 0);
    check({n, "_row_hold"}, bus.row_idx, NR - 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n_wr, done_at;
    for (int i = 0; i < 256; i++) pix[i] = i < 8 ? 8'(10 * (i + 1)) : 8'($urandom);
    bus.start = 0; bus.src_valid = 0; bus.fifo_full = 0;
    repeat (2) cyc(1, 0, 0, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_row", bus.row_idx, 0);
    check("reset_stall", bus.stall_cycles, 0);
    ptr_clr = 1;
    cyc(0, 1, 0, 1);
    check("idle_no_en", bus.gauss_en, 0);
    run_frame("basic", 0, 0, 13);
    ptr_clr = 1;
    cyc(0, 1, 0, 1);
    run_frame("src_gap", 2, 5, 18);
    ptr_clr = 1;
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int c = 3; c <= 5; c++) begin
      cyc(0, 1, 1, 0);
      check("bp_stream_quiet", {bus.src_rd_en, bus.gauss_en, bus.fifo_wr_en}, 0);
    end
    cyc(0, 1, 0, 0);
    check("bp_resume_din", bus.gauss_din, 30);
    check("bp_resume_wr", bus.fifo_wr_en, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int c = 9; c <= 10; c++) begin
      cyc(0, 1, 1, 0);
      check("bp_pad_row", bus.row_idx, 0);
      check("bp_pad_quiet", {bus.gauss_en, bus.fifo_wr_en}, 0);
    end
    cyc(0, 1, 0, 0);
    check("bp_pad_last", {bus.gauss_en, bus.fifo_wr_en, bus.gauss_din}, {2'b11, 8'd0});
    cyc(0, 1, 0, 0);
    check("bp_row1", bus.row_idx, 1);
    check("bp_row1_din", bus.gauss_din, 50);
    done_at = 0;
    for (int c = 13; c <= 40 && done_at == 0; c++) begin
      cyc(0, 1, 0, 0);
      if (bus.frame_done) done_at = c;
    end
    check("bp_done_at", done_at, 18);
`ifdef GAUSS_SEQ_STALL_CNT_EN
    check("stall_total", bus.stall_cycles, 5);
`else
    check("stall_total", bus.stall_cycles, 0);
`endif
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("stall_cleared", bus.stall_cycles, 0);
    for (int c = 1; c <= 10; c++) cyc(0, 1, 0, 0);
    check("pre_rst_row", bus.row_idx, 1);
    check("pre_rst_rd", bus.src_rd_en, 1);
    #2;
    rst = 1;
    #1;
    check("async_rst_outs", {bus.src_rd_en, bus.gauss_en, bus.fifo_wr_en, bus.busy, bus.frame_done, bus.gauss_din}, 0);
    check("async_rst_row", bus.row_idx, 0);
    cyc(1, 1, 0, 0);
    ptr_clr = 1;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    n_wr = 0; done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      cyc(0, 1, 0, c == 3 || c == 7);
      if (bus.fifo_wr_en) n_wr++;
      if (bus.frame_done) done_at = c;
    end
    check("restart_writes", n_wr, 8);
    check("restart_done_at", done_at, 13);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    cyc(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
